// File: rtl/hcall_stream_arb_pkg.sv
// Shared definitions for the hypercall stream arbiter: stream/tryte widths,
// FSM state encodings and a small modular-add helper.
package hcall_stream_arb_pkg;

    localparam int TRYTE_W  = 18;
    localparam int STREAM_W = 32;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_e;

    // (a + b) mod n for a < n, b < n
    function automatic int wrap_add(input int a, input int b, input int n);
        int s;
        s = a + b;
        if (s >= n) s = s - n;
        return s;
    endfunction

endpackage

// File: rtl/hcall_skid_fifo.sv
// Two-entry output FIFO carrying tdata, tlast and the originating source index.
// The head is exposed combinationally and forced to zero while empty.
module hcall_skid_fifo #(
    parameter int P_DATA_W = 32,
    parameter int P_SRC_W  = 1
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                push,
    input  logic [P_DATA_W-1:0] push_data,
    input  logic                push_last,
    input  logic [P_SRC_W-1:0]  push_src,
    output logic                full,
    input  logic                pop,
    output logic                out_valid,
    output logic [P_DATA_W-1:0] out_data,
    output logic                out_last,
    output logic [P_SRC_W-1:0]  out_src
);

    logic [P_DATA_W-1:0] mem_data_reg [2];
    logic                mem_last_reg [2];
    logic [P_SRC_W-1:0]  mem_src_reg  [2];
    logic                wr_ptr_reg;
    logic                rd_ptr_reg;
    logic [1:0]          count_reg;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            for (int i = 0; i < 2; i++) begin
                mem_data_reg[i] <= '0;
                mem_last_reg[i] <= 1'b0;
                mem_src_reg[i]  <= '0;
            end
            wr_ptr_reg <= 1'b0;
            rd_ptr_reg <= 1'b0;
            count_reg  <= 2'd0;
        end else begin
            if (push) begin
                mem_data_reg[wr_ptr_reg] <= push_data;
                mem_last_reg[wr_ptr_reg] <= push_last;
                mem_src_reg[wr_ptr_reg]  <= push_src;
                wr_ptr_reg               <= ~wr_ptr_reg;
            end
            if (pop) rd_ptr_reg <= ~rd_ptr_reg;
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 2'd1;
                2'b01:   count_reg <= count_reg - 2'd1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign full      = (count_reg == 2'd2);
    assign out_valid = (count_reg != 2'd0);
    assign out_data  = out_valid ? mem_data_reg[rd_ptr_reg] : '0;
    assign out_last  = out_valid ? mem_last_reg[rd_ptr_reg] : 1'b0;
    assign out_src   = out_valid ? mem_src_reg[rd_ptr_reg]  : '0;

endmodule

// File: rtl/hcall_stream_arb.sv
// Packet-locked round-robin merge of P_NUM_SRC AXI streams into one host stream.
// Optional per-source packet counters: define HCALL_STREAM_ARB_STATS_EN.
module hcall_stream_arb
    import hcall_stream_arb_pkg::*;
#(
    parameter int P_NUM_SRC = 2,
    parameter int P_DATA_W  = STREAM_W
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic [P_NUM_SRC*P_DATA_W-1:0] s_axis_tdata,
    input  logic [P_NUM_SRC-1:0]          s_axis_tvalid,
    input  logic [P_NUM_SRC-1:0]          s_axis_tlast,
    output logic [P_NUM_SRC-1:0]          s_axis_tready,
    output logic [P_DATA_W-1:0]           m_axis_tdata,
    output logic                          m_axis_tlast,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic [P_NUM_SRC-1:0]          o_grant,
    output logic                          o_busy,
    output logic [P_NUM_SRC*16-1:0]       o_pkt_cnt
);

    localparam int SRC_W = (P_NUM_SRC > 1) ? $clog2(P_NUM_SRC) : 1;

    arb_state_e           state_reg, state_next;
    logic [SRC_W-1:0]     grant_reg, grant_next;
    logic [SRC_W-1:0]     rr_ptr_reg, rr_ptr_next;
    logic [SRC_W-1:0]     sel_idx;
    logic [2*P_NUM_SRC-1:0] valid_dbl;
    logic [P_NUM_SRC-1:0] valid_rot;
    logic                 gr_valid;
    logic                 gr_last;
    logic [P_DATA_W-1:0]  gr_data;
    logic                 s_hs;
    logic                 m_hs;
    logic                 fifo_full;
    logic [SRC_W-1:0]     fifo_src;

    // Rotate valids so bit k is source (rr_ptr + k); lowest set bit wins.
    assign valid_dbl = {s_axis_tvalid, s_axis_tvalid};
    assign valid_rot = P_NUM_SRC'(valid_dbl >> rr_ptr_reg);

    always_comb begin
        sel_idx = rr_ptr_reg;
        for (int k = P_NUM_SRC - 1; k >= 0; k--) begin
            if (valid_rot[k]) sel_idx = SRC_W'(wrap_add(int'(rr_ptr_reg), k, P_NUM_SRC));
        end
    end

    always_comb begin
        gr_valid = 1'b0;
        gr_last  = 1'b0;
        gr_data  = '0;
        for (int i = 0; i < P_NUM_SRC; i++) begin
            if (grant_reg == SRC_W'(i)) begin
                gr_valid = s_axis_tvalid[i];
                gr_last  = s_axis_tlast[i];
                gr_data  = s_axis_tdata[i*P_DATA_W +: P_DATA_W];
            end
        end
    end

    assign s_hs   = (state_reg == BUSY) && gr_valid && !fifo_full;
    assign m_hs   = m_axis_tvalid && m_axis_tready;
    assign o_busy = (state_reg == BUSY);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_reg  <= IDLE;
            grant_reg  <= '0;
            rr_ptr_reg <= '0;
        end else begin
            state_reg  <= state_next;
            grant_reg  <= grant_next;
            rr_ptr_reg <= rr_ptr_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        grant_next  = grant_reg;
        rr_ptr_next = rr_ptr_reg;
        case (state_reg)
            IDLE: begin
                if (|s_axis_tvalid) begin
                    state_next = BUSY;
                    grant_next = sel_idx;
                end
            end
            BUSY: begin
                if (s_hs && gr_last) begin
                    state_next  = IDLE;
                    rr_ptr_next = SRC_W'(wrap_add(int'(grant_reg), 1, P_NUM_SRC));
                end
            end
            default: state_next = IDLE;
        endcase
    end

    for (genvar gi = 0; gi < P_NUM_SRC; gi++) begin : g_src
        assign o_grant[gi]       = (state_reg == BUSY) && (grant_reg == SRC_W'(gi));
        assign s_axis_tready[gi] = o_grant[gi] && !fifo_full;
    end

    hcall_skid_fifo #(
        .P_DATA_W (P_DATA_W),
        .P_SRC_W  (SRC_W)
    ) u_fifo (
        .CLK       (CLK),
        .RST       (RST),
        .push      (s_hs),
        .push_data (gr_data),
        .push_last (gr_last),
        .push_src  (grant_reg),
        .full      (fifo_full),
        .pop       (m_hs),
        .out_valid (m_axis_tvalid),
        .out_data  (m_axis_tdata),
        .out_last  (m_axis_tlast),
        .out_src   (fifo_src)
    );

`ifdef HCALL_STREAM_ARB_STATS_EN
    // Count packets as they leave toward the host, tagged by originating source.
    for (genvar gi = 0; gi < P_NUM_SRC; gi++) begin : g_cnt
        logic [15:0] cnt_reg;
        always_ff @(posedge CLK or negedge RST) begin
            if (!RST) begin
                cnt_reg <= '0;
            end else if (m_hs && m_axis_tlast && (fifo_src == SRC_W'(gi)) && (cnt_reg != 16'hFFFF)) begin
                cnt_reg <= cnt_reg + 16'd1;
            end
        end
        assign o_pkt_cnt[gi*16 +: 16] = cnt_reg;
    end
`else
    logic unused_src;
    assign unused_src = ^fifo_src;
    assign o_pkt_cnt  = '0;
`endif

endmodule

// File: tb/tb_hcall_stream_arb.sv
// Directed scoreboard bench for hcall_stream_arb (two sources, 32-bit data).
module tb_hcall_stream_arb;

    localparam int N = 2;
    localparam int W = 32;

    logic            CLK = 1'b0;
    logic            RST = 1'b0;
    logic [N*W-1:0]  s_axis_tdata = '0;
    logic [N-1:0]    s_axis_tvalid = '0;
    logic [N-1:0]    s_axis_tlast = '0;
    logic [N-1:0]    s_axis_tready;
    logic [W-1:0]    m_axis_tdata;
    logic            m_axis_tlast;
    logic            m_axis_tvalid;
    logic            m_axis_tready = 1'b0;
    logic [N-1:0]    o_grant;
    logic            o_busy;
    logic [N*16-1:0] o_pkt_cnt;

    always #5 CLK = ~CLK;

    hcall_stream_arb #(.P_NUM_SRC(N), .P_DATA_W(W)) dut (
        .CLK           (CLK),
        .RST           (RST),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .o_grant       (o_grant),
        .o_busy        (o_busy),
        .o_pkt_cnt     (o_pkt_cnt)
    );

    int checks   = 0;
    int failures = 0;

    logic [W:0] q0[$];
    logic [W:0] q1[$];
    logic [W:0] sb[$];
    logic [N-1:0] hold = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_srcs();
        s_axis_tvalid[0]              = (q0.size() != 0) && !hold[0];
        {s_axis_tlast[0], s_axis_tdata[W-1:0]}   = (q0.size() != 0) ? q0[0] : '0;
        s_axis_tvalid[1]              = (q1.size() != 0) && !hold[1];
        {s_axis_tlast[1], s_axis_tdata[2*W-1:W]} = (q1.size() != 0) ? q1[0] : '0;
    endtask

    // Source driver: retire words that handshook on the last edge, present the next ones.
    initial begin
        logic [N-1:0] hs;
        forever begin
            @(negedge CLK);
            hs = s_axis_tvalid & s_axis_tready;
            @(posedge CLK);
            #1;
            if (!RST) hs = '0;
            if (hs[0]) void'(q0.pop_front());
            if (hs[1]) void'(q1.pop_front());
            drive_srcs();
        end
    end

    // Output monitor: scoreboard order and stability under backpressure.
    logic         stalled = 1'b0;
    logic [W:0]   held = '0;
    always @(negedge CLK) begin
        if (!RST) begin
            stalled = 1'b0;
        end else begin
            if (stalled)
                chk("m_stable", {m_axis_tvalid, m_axis_tlast, m_axis_tdata}, {1'b1, held});
            stalled = m_axis_tvalid && !m_axis_tready;
            held    = {m_axis_tlast, m_axis_tdata};
            if (m_axis_tvalid && m_axis_tready) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $error("FAIL extra_word observed=%0h expected=none", {m_axis_tlast, m_axis_tdata});
                end else begin
                    chk("m_word", {m_axis_tlast, m_axis_tdata}, sb.pop_front());
                end
            end
        end
    end

    task automatic step();
        @(posedge CLK);
        #2;
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while ((sb.size() != 0 || q0.size() != 0 || q1.size() != 0 || o_busy) && n < 300) begin
            @(negedge CLK);
            n++;
        end
        chk(tag, 64'(n >= 300), 0);
        step();
    endtask

    task automatic reset_pulse();
        step();
        RST = 1'b0;
        step();
        RST = 1'b1;
    endtask

    task automatic wait_busy(input string tag);
        int n = 0;
        while (!o_busy && n < 30) begin
            @(negedge CLK);
            n++;
        end
        chk(tag, 64'(n >= 30), 0);
    endtask

    initial begin
        logic [N-1:0] gseq[$];
        logic [W-1:0] exp_data;
        logic [31:0]  exp_cnt;
        int n;

        // Reset state
        #7;
        chk("rst_m_valid", m_axis_tvalid, 0);
        chk("rst_m_data",  m_axis_tdata, 0);
        chk("rst_m_last",  m_axis_tlast, 0);
        chk("rst_s_ready", s_axis_tready, 0);
        chk("rst_grant",   o_grant, 0);
        chk("rst_busy",    o_busy, 0);
        chk("rst_pkt_cnt", o_pkt_cnt, 0);
        step();
        RST = 1'b1;
        m_axis_tready = 1'b1;

        // Two single-word packets from source 0, one-cycle output latency
        q0.push_back({1'b1, 32'h41}); sb.push_back({1'b1, 32'h41});
        q0.push_back({1'b1, 32'h3});  sb.push_back({1'b1, 32'h3});
        for (int w = 0; w < 2; w++) begin
            n = 0;
            while (!(s_axis_tvalid[0] && s_axis_tready[0]) && n < 20) begin
                @(negedge CLK);
                n++;
            end
            chk("t1_hs_timeout", 64'(n >= 20), 0);
            chk("t1_grant", o_grant, 2'b01);
            @(negedge CLK);
            exp_data = (w == 0) ? 32'h41 : 32'h3;
            chk("t1_m_valid", m_axis_tvalid, 1);
            chk("t1_m_data", m_axis_tdata, exp_data);
        end
        drain("t1_drain");
        chk("t1_idle_grant", o_grant, 0);

        // Simultaneous 3-word packets after reset: source 0 first, no interleave
        reset_pulse();
        for (int i = 0; i < 3; i++) q0.push_back({1'(i == 2), 32'hA0 + 32'(i)});
        for (int i = 0; i < 3; i++) q1.push_back({1'(i == 2), 32'hB0 + 32'(i)});
        for (int i = 0; i < 3; i++) sb.push_back({1'(i == 2), 32'hA0 + 32'(i)});
        for (int i = 0; i < 3; i++) sb.push_back({1'(i == 2), 32'hB0 + 32'(i)});
        for (int c = 0; c < 40; c++) begin
            @(negedge CLK);
            if (o_grant != 0 && (gseq.size() == 0 || gseq[$] != o_grant)) gseq.push_back(o_grant);
        end
        chk("t2_grant_cnt", gseq.size(), 2);
        chk("t2_grant_0", (gseq.size() > 0) ? gseq[0] : 2'b00, 2'b01);
        chk("t2_grant_1", (gseq.size() > 1) ? gseq[1] : 2'b00, 2'b10);
        drain("t2_drain");

        // Single-word packets from both sources alternate per word
        for (int i = 0; i < 3; i++) q0.push_back({1'b1, 32'hC0 + 32'(i)});
        for (int i = 0; i < 3; i++) q1.push_back({1'b1, 32'hD0 + 32'(i)});
        for (int i = 0; i < 3; i++) begin
            sb.push_back({1'b1, 32'hC0 + 32'(i)});
            sb.push_back({1'b1, 32'hD0 + 32'(i)});
        end
        drain("t2b_drain");

        // Host backpressure for 5 cycles mid-packet
        for (int i = 0; i < 6; i++) q0.push_back({1'(i == 5), 32'hE0 + 32'(i)});
        for (int i = 0; i < 6; i++) sb.push_back({1'(i == 5), 32'hE0 + 32'(i)});
        wait_busy("t3_busy");
        step();
        m_axis_tready = 1'b0;
        repeat (5) @(negedge CLK);
        chk("t3_s_ready_low", s_axis_tready[0], 0);
        chk("t3_m_valid_held", m_axis_tvalid, 1);
        step();
        m_axis_tready = 1'b1;
        drain("t3_drain");

        // Gap in granted source while source 1 waits
        for (int i = 0; i < 4; i++) q0.push_back({1'(i == 3), 32'hF0 + 32'(i)});
        for (int i = 0; i < 4; i++) sb.push_back({1'(i == 3), 32'hF0 + 32'(i)});
        sb.push_back({1'b1, 32'h60});
        wait_busy("t4_busy");
        chk("t4_first_grant", o_grant, 2'b01);
        step();
        hold[0] = 1'b1;
        q1.push_back({1'b1, 32'h60});
        for (int c = 0; c < 4; c++) begin
            @(negedge CLK);
            chk("t4_grant_held", o_grant, 2'b01);
            chk("t4_s1_ready", s_axis_tready[1], 0);
        end
        step();
        hold[0] = 1'b0;
        drain("t4_drain");

        // Asynchronous reset while busy with the FIFO full
        m_axis_tready = 1'b0;
        for (int i = 0; i < 4; i++) q0.push_back({1'(i == 3), 32'h70 + 32'(i)});
        n = 0;
        while (!(o_busy && m_axis_tvalid && !s_axis_tready[0]) && n < 30) begin
            @(negedge CLK);
            n++;
        end
        chk("t5_full_timeout", 64'(n >= 30), 0);
        #1;
        RST = 1'b0;
        #1;
        chk("t5_m_valid", m_axis_tvalid, 0);
        chk("t5_busy", o_busy, 0);
        chk("t5_s_ready", s_axis_tready, 0);
        q0.delete();
        q1.delete();
        sb.delete();
        step();
        step();
        RST = 1'b1;
        m_axis_tready = 1'b1;
        q1.push_back({1'b1, 32'h81});
        q0.push_back({1'b1, 32'h80});
        sb.push_back({1'b1, 32'h80});
        sb.push_back({1'b1, 32'h81});
        wait_busy("t5_busy_after");
        chk("t5_first_src", o_grant, 2'b01);
        drain("t5_drain");

        // Packet counters: three packets from source 1
        reset_pulse();
        for (int i = 0; i < 3; i++) begin
            q1.push_back({1'b1, 32'h90 + 32'(i)});
            sb.push_back({1'b1, 32'h90 + 32'(i)});
        end
        drain("t6_drain");
`ifdef HCALL_STREAM_ARB_STATS_EN
        exp_cnt = {16'd3, 16'd0};
`else
        exp_cnt = 32'd0;
`endif
        chk("t6_pkt_cnt", o_pkt_cnt, exp_cnt);

        chk("sb_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hcall_stream_arb.md
HCALL_STREAM_ARB -- requirements
Module: hcall_stream_arb

Interface
REQ-001 SHALL have parameter P_NUM_SRC, default 2, number of stream sources (legal 2..8).
REQ-002 SHALL have parameter P_DATA_W, default 32, tdata width of every stream.
REQ-003 SHALL have port CLK, input, 1, single clock; all state changes on the rising edge.
REQ-004 SHALL have port RST, input, 1, reset: asynchronous, active-low.
REQ-005 SHALL have port s_axis_tdata, input, P_NUM_SRC*P_DATA_W, source data (source i occupies slice i).
REQ-006 SHALL have ports s_axis_tvalid and s_axis_tlast, input, P_NUM_SRC each, per-source valid and end-of-packet.
REQ-007 SHALL have port s_axis_tready, output, P_NUM_SRC, per-source ready.
REQ-008 SHALL have ports m_axis_tdata (P_DATA_W), m_axis_tlast (1) and m_axis_tvalid (1), outputs, merged stream toward the host.
REQ-009 SHALL have port m_axis_tready, input, 1, host ready.
REQ-010 SHALL have port o_grant, output, P_NUM_SRC, one-hot current grant (all zero when idle).
REQ-011 SHALL have port o_busy, output, 1, high while a packet is locked.
REQ-012 SHALL have port o_pkt_cnt, output, P_NUM_SRC*16, per-source delivered-packet counters.

Function
REQ-013 SHALL implement FSM states IDLE and BUSY.
REQ-014 In IDLE with any s_axis_tvalid high, SHALL grant at the next edge the first valid source scanning from rr_ptr upward with wrap-around, then enter BUSY.
REQ-015 In BUSY, s_axis_tready[g] SHALL equal "buffer not full"; all other s_axis_tready bits SHALL be 0.
REQ-016 SHALL hold the grant through any tvalid gaps of the granted source; no other source is served until the packet ends.
REQ-017 On the handshake of the granted source with tlast=1, SHALL return to IDLE at that edge and set rr_ptr=(g+1) mod P_NUM_SRC; one arbitration bubble cycle between packets is required.
REQ-018 Single-word packets (tlast=1 on every word, as hypercall log traffic uses) SHALL therefore rotate fairly per word.
REQ-019 Output path SHALL be a 2-entry FIFO: a word accepted at edge N appears on m_axis at cycle N+1 when the FIFO was empty; sustained throughput 1 word/cycle.
REQ-020 m_axis_tdata/tlast SHALL stay stable while m_axis_tvalid=1 and m_axis_tready=0.
REQ-021 With the FIFO full, s_axis_tready SHALL be 0; a simultaneous push and pop with the FIFO full SHALL NOT occur; push and pop in the same cycle with 1 entry SHALL keep 1 entry.
REQ-022 Words SHALL never be dropped, duplicated or reordered.

Reset
REQ-023 While RST=0: m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, s_axis_tready=0, o_grant=0, o_busy=0, o_pkt_cnt=0, FIFO empty, rr_ptr=0, state IDLE.
REQ-024 Reset mid-packet SHALL discard buffered words immediately (asynchronous); after release the next packet starts at arbitration.

Configuration
REQ-025 Macro HCALL_STREAM_ARB_STATS_EN defined: o_pkt_cnt slice i SHALL increment on each m_axis handshake with tlast=1 whose word came from source i, saturating at 16'hFFFF.
REQ-026 Macro undefined: o_pkt_cnt SHALL be constant 0 and no counter registers SHALL be synthesized.

Structure
REQ-027 Tryte width (18), stream width (32) and FSM state encodings SHALL live in the shared utils header.
REQ-028 The 2-entry FIFO SHALL be a sub-module named hcall_skid_fifo carrying tdata, tlast and a source index.

Verification
REQ-029 Source 0 sends 32'h41 (tlast=1), then 32'h3 (tlast=1), m_axis_tready=1 -> m_axis emits 32'h41 then 32'h3, each one cycle after its source handshake.
REQ-030 Both sources assert 3-word packets (tlast on word 3) in the same cycle after reset -> source 0's 3 words, then source 1's 3 words, no interleaving; o_grant 01 then 10.
REQ-031 m_axis_tready=0 for 5 cycles mid-packet -> s_axis_tready drops after 2 buffered words, all words delivered once in order.
REQ-032 Granted source deasserts tvalid 4 cycles mid-packet while source 1 valid -> grant held, s_axis_tready[1]=0 throughout.
REQ-033 RST=0 asserted in BUSY with 2 words buffered -> m_axis_tvalid=0 and o_busy=0 without waiting for a clock edge; next packet after release starts from source 0.
REQ-034 With HCALL_STREAM_ARB_STATS_EN, source 1 sends 3 packets -> o_pkt_cnt[31:16]=3, o_pkt_cnt[15:0]=0; without the macro both slices read 0.
